mpsoc_wb_pic: RTL and testbench

- Parametrised Wishbone-slave interrupt controller. Replaces hard-wired per-line tie-offs on the CPU irq_i vector.
- Aggregates NUM_IRQ peripheral interrupt lines (UART, timers, future blocks). Each line has:
  - optional input synchronisation
  - per-line level/edge mode and polarity
  - masking and sticky pending state
- Drives the masked interrupt vector to the CPU and sits on the data-bus interconnect as a slave.

---
 rtl/mpsoc_pic_pkg.sv | 42 ++++
 rtl/mpsoc_pic_line.sv | 60 ++++++
 rtl/mpsoc_wb_pic.sv | 144 ++++++++++++++
 tb/tb_mpsoc_wb_pic.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mpsoc_pic_pkg.sv
// Shared constants and helpers for the Wishbone interrupt controller.
// Register word indices, bus FSM states and small bit-manipulation functions.
package mpsoc_pic_pkg;

  localparam logic [2:0] PIC_MASK    = 3'd0;
  localparam logic [2:0] PIC_MODE    = 3'd1;
  localparam logic [2:0] PIC_POL     = 3'd2;
  localparam logic [2:0] PIC_PENDING = 3'd3;
  localparam logic [2:0] PIC_STATUS  = 3'd4;
  localparam logic [2:0] PIC_HIGHEST = 3'd5;

  localparam int PIC_NUM_REGS          = 6;
  localparam int PIC_HIGHEST_VALID_BIT = 31;

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_t;

  // Expands the four Wishbone byte enables into a 32-bit bit mask.
  function automatic logic [31:0] byte_lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

  // Index of the lowest-numbered set bit; 0 when no bit is set.
  function automatic logic [4:0] lowest_set_index(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mpsoc_pic_line.sv
// One interrupt line: optional synchroniser, polarity inversion, edge history
// and the sticky/level pending flop.
module mpsoc_pic_line #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_raw,
  input  logic mode,
  input  logic pol,
  input  logic clr,
  output logic pending
);

  logic s;
  logic a;
  logic h;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = irq_raw;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= irq_raw;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign a = s ^ pol;

  // h tracks a every cycle regardless of mode, so a mode or polarity change
  // only produces an edge when a really goes 0->1. Set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h       <= 1'b0;
      pending <= 1'b0;
    end else begin
      h <= a;
      if (!mode) begin
        pending <= a;
      end else if (a && !h) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mpsoc_wb_pic.sv
// Wishbone-slave interrupt controller: bus FSM, MASK/MODE/POL registers,
// per-line pending logic and a lowest-index priority encoder.
module mpsoc_wb_pic
  import mpsoc_pic_pkg::*;
#(
  parameter int NUM_IRQ     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [DW-1:0]      wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [DW-1:0]      wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic               irq_any_o
);

  bus_state_t state;

  logic [2:0]         reg_idx;
  logic               req;
  logic               mapped;
  logic               wr_fire;
  logic [31:0]        lane_mask;
  logic [NUM_IRQ-1:0] lane_n;
  logic [NUM_IRQ-1:0] dat_n;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] mode_q;
  logic [NUM_IRQ-1:0] pol_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] status;
  logic [NUM_IRQ-1:0] clr;
  logic [31:0]        status_full;
  logic [31:0]        highest_val;
  logic [31:0]        rd_data;
  logic               unused_bits;

  assign reg_idx   = wb_adr_i[4:2];
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign mapped    = (reg_idx <= PIC_HIGHEST);
  assign wr_fire   = req & wb_we_i & mapped;
  assign lane_mask = byte_lane_mask(wb_sel_i);
  assign lane_n    = lane_mask[NUM_IRQ-1:0];
  assign dat_n     = wb_dat_i[NUM_IRQ-1:0];
  assign clr       = (wr_fire && reg_idx == PIC_PENDING) ? (dat_n & lane_n) : '0;

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i, lane_mask};

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
      mpsoc_pic_line #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_line (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .irq_raw (irq_i[gi]),
        .mode    (mode_q[gi]),
        .pol     (pol_q[gi]),
        .clr     (clr[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

  assign status      = pending & mask_q;
  assign status_full = 32'(status);
  assign irq_o       = status;
  assign irq_any_o   = |status;

  always_comb begin
    highest_val                        = '0;
    highest_val[PIC_HIGHEST_VALID_BIT] = |status_full;
    highest_val[4:0]                   = lowest_set_index(status_full);
  end

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      PIC_MASK:    rd_data = 32'(mask_q);
      PIC_MODE:    rd_data = 32'(mode_q);
      PIC_POL:     rd_data = 32'(pol_q);
      PIC_PENDING: rd_data = 32'(pending);
      PIC_STATUS:  rd_data = status_full;
      PIC_HIGHEST: rd_data = highest_val;
      default:     rd_data = '0;
    endcase
  end

  // Configuration writes land on the same edge that raises ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mask_q <= '0;
      mode_q <= '0;
      pol_q  <= '0;
    end else if (wr_fire) begin
      case (reg_idx)
        PIC_MASK: mask_q <= (mask_q & ~lane_n) | (dat_n & lane_n);
        PIC_MODE: mode_q <= (mode_q & ~lane_n) | (dat_n & lane_n);
        PIC_POL:  pol_q  <= (pol_q  & ~lane_n) | (dat_n & lane_n);
        default: ;
      endcase
    end
  end

  // Single-cycle responder: one ack/err pulse per request, then back to idle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= BUS_IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      case (state)
        BUS_IDLE: begin
          if (req) begin
            state    <= BUS_RESP;
            wb_ack_o <= mapped;
            wb_err_o <= ~mapped;
            wb_dat_o <= rd_data;
          end
        end
        BUS_RESP: begin
          state    <= BUS_IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
        end
        default: begin
          state    <= BUS_IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_wb_pic.sv
// Directed scoreboard bench for mpsoc_wb_pic: a default 32-line instance with
// two synchroniser stages and a 5-line instance without synchronisers.
module tb_mpsoc_wb_pic;
  import mpsoc_pic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc_a, stb_a, cyc_b, stb_b;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, err_a, ack_b, err_b;
  logic [31:0] irq_in_a, irq_out_a;
  logic        any_a;
  logic [4:0]  irq_in_b, irq_out_b;
  logic        any_b;

  typedef struct {
    string       tag;
    logic [31:0] data;
    bit          is_err;
    bit          chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mpsoc_wb_pic #(.NUM_IRQ(32), .SYNC_STAGES(2), .DW(32)) dut_a (
    .wb_clk_i (clk),   .wb_rst_i (rst),   .wb_adr_i (adr),  .wb_dat_i (wdat),
    .wb_sel_i (sel),   .wb_we_i  (we),    .wb_cyc_i (cyc_a), .wb_stb_i (stb_a),
    .wb_dat_o (dat_a), .wb_ack_o (ack_a), .wb_err_o (err_a),
    .irq_i    (irq_in_a), .irq_o (irq_out_a), .irq_any_o (any_a)
  );

  mpsoc_wb_pic #(.NUM_IRQ(5), .SYNC_STAGES(0), .DW(32)) dut_b (
    .wb_clk_i (clk),   .wb_rst_i (rst),   .wb_adr_i (adr),  .wb_dat_i (wdat),
    .wb_sel_i (sel),   .wb_we_i  (we),    .wb_cyc_i (cyc_b), .wb_stb_i (stb_b),
    .wb_dat_o (dat_b), .wb_ack_o (ack_b), .wb_err_o (err_b),
    .irq_i    (irq_in_b), .irq_o (irq_out_b), .irq_any_o (any_b)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Waits for the response, releases the bus and scores it against the queue head.
  task automatic checkOutput(input bit tgt);
    exp_t        e;
    bit          got;
    logic        ack, err;
    logic [31:0] dat;
    got = 1'b0;
    ack = 1'b0;
    err = 1'b0;
    dat = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      ack = tgt ? ack_b : ack_a;
      err = tgt ? err_b : err_a;
      dat = tgt ? dat_b : dat_a;
      if (ack || err) got = 1'b1;
    end
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0; we = 1'b0;
    e = sb.pop_front();
    checkValue({e.tag, " response"}, {31'b0, ack | err}, 32'd1);
    checkValue({e.tag, " ack"}, {31'b0, ack}, {31'b0, ~e.is_err});
    checkValue({e.tag, " err"}, {31'b0, err}, {31'b0, e.is_err});
    if (e.chk_data) checkValue({e.tag, " data"}, dat, e.data);
  endtask

  task automatic applyStimulus(input bit tgt, input string tag, input logic [2:0] idx,
                               input logic wr, input logic [31:0] d, input logic [3:0] s,
                               input logic [31:0] exp_data, input bit exp_err);
    exp_t e;
    e.tag      = tag;
    e.data     = exp_data;
    e.is_err   = exp_err;
    e.chk_data = !wr && !exp_err;
    sb.push_back(e);
    adr  = {idx, 2'b00};
    we   = wr;
    wdat = d;
    sel  = s;
    if (tgt) begin cyc_b = 1'b1; stb_b = 1'b1; end
    else     begin cyc_a = 1'b1; stb_a = 1'b1; end
    checkOutput(tgt);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; adr = '0; wdat = '0; sel = '0; we = 1'b0;
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    irq_in_a = 32'hFFFF_FFFF; irq_in_b = '0;

    // Reset state and level capture of all-ones inputs
    repeat (2) @(negedge clk);
    checkValue("reset irq_o", irq_out_a, 32'h0);
    checkValue("reset ack/err/any", {29'b0, ack_a, err_a, any_a}, 32'h0);
    checkValue("reset dat_o", dat_a, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(0, "rd STATUS after reset", PIC_STATUS, 0, 0, 4'hF, 32'h0, 0);
    applyStimulus(0, "rd PENDING after reset", PIC_PENDING, 0, 0, 4'hF, 32'hFFFF_FFFF, 0);
    checkValue("irq_o unmasked", irq_out_a, 32'h0);

    // Mask and level behaviour
    irq_in_a = 32'h4;
    repeat (4) @(negedge clk);
    checkValue("irq_o before MASK write", irq_out_a, 32'h0);
    applyStimulus(0, "wr MASK 4", PIC_MASK, 1, 32'h4, 4'hF, 32'h0, 0);
    checkValue("irq_o on MASK ack", irq_out_a, 32'h4);
    checkValue("irq_any level", {31'b0, any_a}, 32'h1);
    applyStimulus(0, "rd HIGHEST line2", PIC_HIGHEST, 0, 0, 4'hF, 32'h8000_0002, 0);
    applyStimulus(0, "wr MASK lane1", PIC_MASK, 1, 32'hFFFF_FFFF, 4'b0010, 32'h0, 0);
    applyStimulus(0, "rd MASK lane1", PIC_MASK, 0, 0, 4'hF, 32'h0000_FF04, 0);
    applyStimulus(0, "wr MASK 4 again", PIC_MASK, 1, 32'h4, 4'hF, 32'h0, 0);
    irq_in_a = 32'h0;
    @(negedge clk); checkValue("level drop edge1", irq_out_a, 32'h4);
    @(negedge clk); checkValue("level drop edge2", irq_out_a, 32'h4);
    @(negedge clk); checkValue("level drop edge3", irq_out_a, 32'h0);
    checkValue("irq_any cleared", {31'b0, any_a}, 32'h0);
    applyStimulus(0, "rd HIGHEST empty", PIC_HIGHEST, 0, 0, 4'hF, 32'h0, 0);

    // Edge mode: sticky pending, W1C, lane-gated clear
    applyStimulus(0, "wr MODE 1", PIC_MODE, 1, 32'h1, 4'hF, 32'h0, 0);
    applyStimulus(0, "wr MASK 1", PIC_MASK, 1, 32'h1, 4'hF, 32'h0, 0);
    irq_in_a = 32'h1; @(negedge clk); irq_in_a = 32'h0;
    repeat (4) @(negedge clk);
    checkValue("edge sticky irq_o", irq_out_a, 32'h1);
    applyStimulus(0, "rd PENDING edge", PIC_PENDING, 0, 0, 4'hF, 32'h1, 0);
    applyStimulus(0, "wr PENDING clear", PIC_PENDING, 1, 32'h1, 4'hF, 32'h0, 0);
    applyStimulus(0, "rd PENDING cleared", PIC_PENDING, 0, 0, 4'hF, 32'h0, 0);
    checkValue("edge cleared irq_o", irq_out_a, 32'h0);
    irq_in_a = 32'h1; @(negedge clk); irq_in_a = 32'h0;
    repeat (4) @(negedge clk);
    applyStimulus(0, "wr PENDING sel0", PIC_PENDING, 1, 32'h1, 4'h0, 32'h0, 0);
    applyStimulus(0, "rd PENDING after sel0", PIC_PENDING, 0, 0, 4'hF, 32'h1, 0);

    // Set and clear on the same edge: set wins
    applyStimulus(0, "wr PENDING pre-clear", PIC_PENDING, 1, 32'h1, 4'hF, 32'h0, 0);
    repeat (2) @(negedge clk);
    irq_in_a = 32'h1;
    @(negedge clk);
    @(negedge clk);
    applyStimulus(0, "wr PENDING collide", PIC_PENDING, 1, 32'h1, 4'hF, 32'h0, 0);
    applyStimulus(0, "rd PENDING collide", PIC_PENDING, 0, 0, 4'hF, 32'h1, 0);
    irq_in_a = 32'h0;

    // Polarity and unmapped accesses
    applyStimulus(0, "wr POL 8", PIC_POL, 1, 32'h8, 4'hF, 32'h0, 0);
    applyStimulus(0, "wr MASK 8", PIC_MASK, 1, 32'h8, 4'hF, 32'h0, 0);
    repeat (4) @(negedge clk);
    checkValue("active-low irq_o", irq_out_a, 32'h8);
    applyStimulus(0, "rd HIGHEST line3", PIC_HIGHEST, 0, 0, 4'hF, 32'h8000_0003, 0);
    applyStimulus(0, "rd idx6", 3'd6, 0, 0, 4'hF, 32'h0, 1);
    @(negedge clk);
    checkValue("err single pulse", {30'b0, ack_a, err_a}, 32'h0);
    applyStimulus(0, "wr idx6", 3'd6, 1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
    applyStimulus(0, "wr idx7", 3'd7, 1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
    applyStimulus(0, "rd MASK after unmapped", PIC_MASK, 0, 0, 4'hF, 32'h8, 0);
    applyStimulus(0, "rd MODE after unmapped", PIC_MODE, 0, 0, 4'hF, 32'h1, 0);
    applyStimulus(0, "rd POL after unmapped", PIC_POL, 0, 0, 4'hF, 32'h8, 0);
    applyStimulus(0, "rd PENDING after unmapped", PIC_PENDING, 0, 0, 4'hF, 32'h9, 0);

    // Asynchronous reset clears outputs before any clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkValue("async reset irq_o", irq_out_a, 32'h0);
    checkValue("async reset any", {31'b0, any_a}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, "rd MASK after reset", PIC_MASK, 0, 0, 4'hF, 32'h0, 0);

    // Narrow instance: 5 lines, no synchroniser
    applyStimulus(1, "B wr MASK all", PIC_MASK, 1, 32'hFFFF_FFFF, 4'hF, 32'h0, 0);
    applyStimulus(1, "B rd MASK", PIC_MASK, 0, 0, 4'hF, 32'h0000_001F, 0);
    applyStimulus(1, "B wr POL all", PIC_POL, 1, 32'hFFFF_FFFF, 4'hF, 32'h0, 0);
    applyStimulus(1, "B rd POL", PIC_POL, 0, 0, 4'hF, 32'h0000_001F, 0);
    applyStimulus(1, "B wr POL 0", PIC_POL, 1, 32'h0, 4'hF, 32'h0, 0);
    @(negedge clk);
    checkValue("B idle irq_o", {27'b0, irq_out_b}, 32'h0);
    irq_in_b = 5'b00100;
    #1;
    checkValue("B before edge", {27'b0, irq_out_b}, 32'h0);
    @(negedge clk);
    checkValue("B after 1 edge", {27'b0, irq_out_b}, 32'h4);
    checkValue("B irq_any", {31'b0, any_b}, 32'h1);
    applyStimulus(1, "B rd HIGHEST", PIC_HIGHEST, 0, 0, 4'hF, 32'h8000_0002, 0);
    irq_in_b = 5'b10110;
    @(negedge clk);
    applyStimulus(1, "B rd STATUS multi", PIC_STATUS, 0, 0, 4'hF, 32'h0000_0016, 0);
    applyStimulus(1, "B rd HIGHEST multi", PIC_HIGHEST, 0, 0, 4'hF, 32'h8000_0001, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
